// File: rtl/reg_trace_bank.sv
// Host-programmable pattern/mask trace rule bank: shadow registers written over the
// register bus, copied to the active set one rule per cycle by a commit sequencer.
module reg_trace_bank #(
  parameter int         pBYTECNT_SIZE = 7,
  parameter int         pBUFFER_SIZE  = 64,
  parameter int         pMATCH_RULES  = 8,
  parameter int         pCOUNT_WIDTH  = 8,
  parameter logic [1:0] pREG_SELECT   = 2'b01
) (
  input  logic                                 usb_clk,
  input  logic                                 reset_n,
  input  logic [7:0]                           reg_address,
  input  logic [pBYTECNT_SIZE-1:0]             reg_bytecnt,
  input  logic [7:0]                           write_data,
  output logic [7:0]                           read_data,
  input  logic                                 reg_read,
  input  logic                                 reg_write,
  input  logic                                 reg_addrvalid,
  output logic                                 selected,
  input  logic                                 I_synchronized,
  input  logic [pBUFFER_SIZE-1:0]              I_matched_data,
  input  logic [pMATCH_RULES*pCOUNT_WIDTH-1:0] I_trace_count,
  output logic [pMATCH_RULES-1:0]              O_pattern_enable,
  output logic [pMATCH_RULES-1:0]              O_pattern_trig_enable,
  output logic [2:0]                           O_trace_width,
  output logic [pMATCH_RULES*pBUFFER_SIZE-1:0] O_patterns,
  output logic [pMATCH_RULES*pBUFFER_SIZE-1:0] O_masks,
  output logic                                 O_busy,
  output logic                                 O_update
);

  localparam int NR = pMATCH_RULES;
  localparam int BW = pBUFFER_SIZE;
  localparam int BB = pBUFFER_SIZE / 8;
  localparam int CB = (pMATCH_RULES * pCOUNT_WIDTH) / 8;
  localparam int IW = (pMATCH_RULES > 1) ? $clog2(pMATCH_RULES) : 1;

  // "ArmTrac2" with the first character in byte 0
  localparam logic [63:0] NAME_STR = 64'h3263_6172_546d_7241;

  localparam logic [5:0] A_NAME = 6'h00, A_REV = 6'h01, A_PEN = 6'h02, A_PTEN = 6'h03;
  localparam logic [5:0] A_TW = 6'h04, A_SYNC = 6'h05, A_RSEL = 6'h06, A_PAT = 6'h07;
  localparam logic [5:0] A_MASK = 6'h08, A_COMMIT = 6'h09, A_SNAP = 6'h0A;
  localparam logic [5:0] A_NRULES = 6'h0B, A_MDATA = 6'h0C;

  typedef enum logic [1:0] {IDLE, COPY, DONE} state_t;

  state_t                  state_q, state_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [BW-1:0]           sh_pat_q [NR];
  logic [BW-1:0]           sh_pat_d [NR];
  logic [BW-1:0]           sh_mask_q [NR];
  logic [BW-1:0]           sh_mask_d [NR];
  logic [BW-1:0]           act_pat_q [NR];
  logic [BW-1:0]           act_pat_d [NR];
  logic [BW-1:0]           act_mask_q [NR];
  logic [BW-1:0]           act_mask_d [NR];
  logic [NR-1:0]           sh_en_q, sh_en_d, sh_ten_q, sh_ten_d;
  logic [NR-1:0]           en_q, en_d, ten_q, ten_d;
  logic [2:0]              width_q, width_d;
  logic [7:0]              rsel_q, rsel_d;
  logic [NR*pCOUNT_WIDTH-1:0] snap_q, snap_d;
  logic [7:0]              rdata_q, rdata_d;
  logic [7:0]              rd_mux;
  logic [5:0]              addr;
  logic                    wr, busy, byte0;

  assign selected = reg_addrvalid && (reg_address[7:6] == pREG_SELECT);
  assign addr     = reg_address[5:0];
  assign wr       = selected && reg_write;
  assign busy     = (state_q != IDLE);
  assign byte0    = (reg_bytecnt == '0);

  always_comb begin
    rd_mux = 8'h00;
    case (addr)
      A_NAME:
        for (int b = 0; b < 8; b++)
          if (reg_bytecnt == pBYTECNT_SIZE'(b)) rd_mux = NAME_STR[b*8 +: 8];
      A_REV:    if (byte0) rd_mux = 8'h02;
      A_PEN:
        for (int b = 0; b < NR; b++)
          if (reg_bytecnt == pBYTECNT_SIZE'(b / 8)) rd_mux[b % 8] = sh_en_q[b];
      A_PTEN:
        for (int b = 0; b < NR; b++)
          if (reg_bytecnt == pBYTECNT_SIZE'(b / 8)) rd_mux[b % 8] = sh_ten_q[b];
      A_TW:     if (byte0) rd_mux = {5'b0, width_q};
      A_SYNC:   if (byte0) rd_mux = {7'b0, I_synchronized};
      A_RSEL:   if (byte0) rd_mux = rsel_q;
      A_PAT:
        for (int r = 0; r < NR; r++)
          if (rsel_q == 8'(r))
            for (int b = 0; b < BB; b++)
              if (reg_bytecnt == pBYTECNT_SIZE'(b)) rd_mux = sh_pat_q[r][b*8 +: 8];
      A_MASK:
        for (int r = 0; r < NR; r++)
          if (rsel_q == 8'(r))
            for (int b = 0; b < BB; b++)
              if (reg_bytecnt == pBYTECNT_SIZE'(b)) rd_mux = sh_mask_q[r][b*8 +: 8];
      A_COMMIT: if (byte0) rd_mux = {7'b0, busy};
      A_SNAP:
        for (int b = 0; b < CB; b++)
          if (reg_bytecnt == pBYTECNT_SIZE'(b)) rd_mux = snap_q[b*8 +: 8];
      A_NRULES: if (byte0) rd_mux = 8'(NR);
      A_MDATA:
        for (int b = 0; b < BB; b++)
          if (reg_bytecnt == pBYTECNT_SIZE'(b)) rd_mux = I_matched_data[b*8 +: 8];
      default:  rd_mux = 8'h00;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    sh_pat_d   = sh_pat_q;
    sh_mask_d  = sh_mask_q;
    act_pat_d  = act_pat_q;
    act_mask_d = act_mask_q;
    sh_en_d    = sh_en_q;
    sh_ten_d   = sh_ten_q;
    en_d       = en_q;
    ten_d      = ten_q;
    width_d    = width_q;
    rsel_d     = rsel_q;
    snap_d     = snap_q;
    rdata_d    = (reg_read && selected) ? rd_mux : 8'h00;

    // Register writes; shadow state is frozen while a commit is in flight
    if (wr) begin
      case (addr)
        A_PEN:
          if (!busy)
            for (int b = 0; b < NR; b++)
              if (reg_bytecnt == pBYTECNT_SIZE'(b / 8)) sh_en_d[b] = write_data[b % 8];
        A_PTEN:
          if (!busy)
            for (int b = 0; b < NR; b++)
              if (reg_bytecnt == pBYTECNT_SIZE'(b / 8)) sh_ten_d[b] = write_data[b % 8];
        A_TW:   if (byte0) width_d = write_data[2:0];
        A_RSEL: if (!busy && byte0) rsel_d = write_data;
        A_PAT:
          if (!busy)
            for (int r = 0; r < NR; r++)
              if (rsel_q == 8'(r))
                for (int b = 0; b < BB; b++)
                  if (reg_bytecnt == pBYTECNT_SIZE'(b)) sh_pat_d[r][b*8 +: 8] = write_data;
        A_MASK:
          if (!busy)
            for (int r = 0; r < NR; r++)
              if (rsel_q == 8'(r))
                for (int b = 0; b < BB; b++)
                  if (reg_bytecnt == pBYTECNT_SIZE'(b)) sh_mask_d[r][b*8 +: 8] = write_data;
        A_SNAP: snap_d = I_trace_count;
        default: ;
      endcase
    end

    // Commit sequencer: enables held low while the active set is partially updated
    case (state_q)
      IDLE:
        if (wr && addr == A_COMMIT) begin
          state_d = COPY;
          idx_d   = '0;
          en_d    = '0;
          ten_d   = '0;
        end
      COPY: begin
        for (int r = 0; r < NR; r++)
          if (idx_q == IW'(r)) begin
            act_pat_d[r]  = sh_pat_q[r];
            act_mask_d[r] = sh_mask_q[r];
          end
        idx_d = idx_q + 1'b1;
        if (idx_q == IW'(NR - 1)) begin
          state_d = DONE;
          en_d    = sh_en_q;
          ten_d   = sh_ten_q;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge usb_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      for (int r = 0; r < NR; r++) begin
        sh_pat_q[r]   <= '0;
        sh_mask_q[r]  <= '1;
        act_pat_q[r]  <= '0;
        act_mask_q[r] <= '1;
      end
      sh_en_q  <= '0;
      sh_ten_q <= '0;
      en_q     <= '0;
      ten_q    <= '0;
      width_q  <= 3'd4;
      rsel_q   <= 8'h00;
      snap_q   <= '0;
      rdata_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      sh_pat_q   <= sh_pat_d;
      sh_mask_q  <= sh_mask_d;
      act_pat_q  <= act_pat_d;
      act_mask_q <= act_mask_d;
      sh_en_q    <= sh_en_d;
      sh_ten_q   <= sh_ten_d;
      en_q       <= en_d;
      ten_q      <= ten_d;
      width_q    <= width_d;
      rsel_q     <= rsel_d;
      snap_q     <= snap_d;
      rdata_q    <= rdata_d;
    end
  end

  always_comb begin
    O_patterns = '0;
    O_masks    = '0;
    for (int r = 0; r < NR; r++) begin
      O_patterns[r*BW +: BW] = act_pat_q[r];
      O_masks[r*BW +: BW]    = act_mask_q[r];
    end
  end

  assign read_data             = rdata_q;
  assign O_pattern_enable      = en_q;
  assign O_pattern_trig_enable = ten_q;
  assign O_trace_width         = width_q;
  assign O_busy                = busy;
  assign O_update              = (state_q == DONE);

endmodule
